// File: rtl/usb2m4_byte_fifo.sv
// Single-clock FWFT byte FIFO between the USB serial bridge endpoint and the M4 register side.
// Optional macro USB2M4_FIFO_ERR_CNT_EN adds saturating overflow/underflow counters (ovf_cnt, udf_cnt).
module usb2m4_byte_fifo #(
   parameter int ADDR_WIDTH = 9,
   parameter int DATA_WIDTH = 8,
   parameter int AF_LEVEL   = 4,
   parameter int AE_LEVEL   = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] din,
   output logic                  full,
   output logic                  af,
   output logic [3:0]            pushflag,
   input  logic                  pop,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  empty,
   output logic                  ae,
   output logic [3:0]            popflag,
   output logic [ADDR_WIDTH:0]   count
`ifdef USB2M4_FIFO_ERR_CNT_EN
   ,
   output logic [7:0]            ovf_cnt,
   output logic [7:0]            udf_cnt
`endif
);

   localparam int CW    = ADDR_WIDTH + 1;
   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [CW-1:0]         DEPTH_C   = CW'(DEPTH);
   localparam logic [CW-1:0]         AF_C      = CW'(AF_LEVEL);
   localparam logic [CW-1:0]         AE_C      = CW'(AE_LEVEL);
   localparam logic [CW-1:0]         LVL_SAT_C = CW'(15);
   localparam logic [CW-1:0]         CNT_ONE_C = CW'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE_C = ADDR_WIDTH'(1);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr_r;
   logic [ADDR_WIDTH-1:0] rd_ptr_r;
   logic [CW-1:0]         count_r;
   logic                  empty_r;
   logic                  full_r;
   logic                  ae_r;
   logic                  af_r;
   logic [3:0]            popflag_r;
   logic [3:0]            pushflag_r;

   logic                  pop_ok_s;
   logic                  push_ok_s;
   logic [CW-1:0]         count_nxt_s;
   logic [CW-1:0]         free_nxt_s;

   // Saturating 4-bit level as consumed by the bridge endpoint.
   function automatic logic [3:0] level4(input logic [CW-1:0] v);
      logic [3:0] lvl_s;
      if (v >= LVL_SAT_C) begin
         lvl_s = 4'hF;
      end else begin
         lvl_s = v[3:0];
      end
      return lvl_s;
   endfunction

   // Acceptance of this cycle's requests and the resulting occupancy.
   always_comb begin
      pop_ok_s    = pop & ~empty_r;
      push_ok_s   = push & (~full_r | pop_ok_s);
      count_nxt_s = count_r;
      if (flush) begin
         count_nxt_s = '0;
      end else begin
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE_C;
            2'b01:   count_nxt_s = count_r - CNT_ONE_C;
            default: count_nxt_s = count_r;
         endcase
      end
      free_nxt_s = DEPTH_C - count_nxt_s;
   end

   // Pointers, occupancy and flags; flags are registered from the next occupancy.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_r   <= '0;
         rd_ptr_r   <= '0;
         count_r    <= '0;
         empty_r    <= 1'b1;
         full_r     <= 1'b0;
         ae_r       <= 1'b1;
         af_r       <= 1'b0;
         popflag_r  <= 4'h0;
         pushflag_r <= 4'hF;
      end else begin
         if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
         end else begin
            if (push_ok_s) begin
               wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
            end
            if (pop_ok_s) begin
               rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
            end
         end
         count_r    <= count_nxt_s;
         empty_r    <= (count_nxt_s == '0);
         full_r     <= (count_nxt_s == DEPTH_C);
         ae_r       <= (count_nxt_s <= AE_C);
         af_r       <= (free_nxt_s <= AF_C);
         popflag_r  <= level4(count_nxt_s);
         pushflag_r <= level4(free_nxt_s);
      end
   end

   // Storage array; contents deliberately not reset, flushed writes are dropped.
   always_ff @(posedge clk) begin
      if (push_ok_s && !flush) begin
         mem_r[wr_ptr_r] <= din;
      end
   end

   assign dout     = empty_r ? '0 : mem_r[rd_ptr_r];
   assign count    = count_r;
   assign empty    = empty_r;
   assign full     = full_r;
   assign ae       = ae_r;
   assign af       = af_r;
   assign popflag  = popflag_r;
   assign pushflag = pushflag_r;

`ifdef USB2M4_FIFO_ERR_CNT_EN
   logic [7:0] ovf_cnt_r;
   logic [7:0] udf_cnt_r;

   // Saturating counters of ignored pushes and pops issued while empty.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ovf_cnt_r <= 8'h00;
         udf_cnt_r <= 8'h00;
      end else if (flush) begin
         ovf_cnt_r <= 8'h00;
         udf_cnt_r <= 8'h00;
      end else begin
         if (push && full_r && !pop_ok_s && (ovf_cnt_r != 8'hFF)) begin
            ovf_cnt_r <= ovf_cnt_r + 8'h01;
         end
         if (pop && empty_r && (udf_cnt_r != 8'hFF)) begin
            udf_cnt_r <= udf_cnt_r + 8'h01;
         end
      end
   end

   assign ovf_cnt = ovf_cnt_r;
   assign udf_cnt = udf_cnt_r;
`endif

endmodule

// File: tb/tb_usb2m4_byte_fifo.sv
// Scoreboard bench for usb2m4_byte_fifo: queue-based reference model, randomized and directed traffic.
// Checks ovf_cnt/udf_cnt too when USB2M4_FIFO_ERR_CNT_EN is defined.
module tb_usb2m4_byte_fifo;

   localparam int DEPTH = 512;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       flush = 1'b0;
   logic       push = 1'b0;
   logic [7:0] din = 8'h00;
   logic       pop = 1'b0;
   logic       full, af, empty, ae;
   logic [3:0] pushflag, popflag;
   logic [7:0] dout;
   logic [9:0] count;
`ifdef USB2M4_FIFO_ERR_CNT_EN
   logic [7:0] ovf_cnt, udf_cnt;
`endif

   usb2m4_byte_fifo dut (
      .clk(clk), .reset(reset), .flush(flush), .push(push), .din(din),
      .full(full), .af(af), .pushflag(pushflag), .pop(pop), .dout(dout),
      .empty(empty), .ae(ae), .popflag(popflag), .count(count)
`ifdef USB2M4_FIFO_ERR_CNT_EN
      , .ovf_cnt(ovf_cnt), .udf_cnt(udf_cnt)
`endif
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input int unsigned act, input int unsigned exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: FIFO contents as a queue, popped bytes go to the scoreboard.
   logic [7:0] ref_q[$];
   logic [7:0] exp_q[$];
   int         ovf_m = 0;
   int         udf_m = 0;

   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         ref_q.delete();
         ovf_m = 0;
         udf_m = 0;
      end else if (flush) begin
         ref_q.delete();
         ovf_m = 0;
         udf_m = 0;
      end else begin
         int  n;
         bit  p_ok, w_ok;
         n    = ref_q.size();
         p_ok = pop && (n > 0);
         w_ok = push && ((n < DEPTH) || p_ok);
         if (push && (n == DEPTH) && !p_ok && ovf_m < 255) ovf_m++;
         if (pop && (n == 0) && udf_m < 255) udf_m++;
         if (p_ok) exp_q.push_back(ref_q.pop_front());
         if (w_ok) ref_q.push_back(din);
      end
   end

   // Monitor: compares popped data against the scoreboard and state against the model.
   bit         pend_v = 1'b0;
   logic [7:0] pend_d;

   always @(negedge clk) begin
      int n, fr;
      if (pend_v) begin
         if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL pop_data: got %0h expected nothing", pend_d);
         end else begin
            chk("pop_data", pend_d, exp_q.pop_front());
         end
         pend_v = 1'b0;
      end
      n  = ref_q.size();
      fr = DEPTH - n;
      chk("count", count, n);
      chk("empty", empty, n == 0);
      chk("full", full, n == DEPTH);
      chk("ae", ae, n <= 4);
      chk("af", af, fr <= 4);
      chk("popflag", popflag, (n >= 15) ? 15 : n);
      chk("pushflag", pushflag, (fr >= 15) ? 15 : fr);
      chk("dout", dout, (n > 0) ? ref_q[0] : 0);
`ifdef USB2M4_FIFO_ERR_CNT_EN
      chk("ovf_cnt", ovf_cnt, ovf_m);
      chk("udf_cnt", udf_cnt, udf_m);
`endif
      if (reset && pop && !empty && !flush) begin
         pend_v = 1'b1;
         pend_d = dout;
      end
   end

   task automatic step(input logic p, input logic [7:0] d, input logic q, input logic f);
      push = p; din = d; pop = q; flush = f;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset state
      step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("rst_count", count, 0);
      chk("rst_empty", empty, 1);
      chk("rst_pushflag", pushflag, 4'hF);
      #2 reset = 1'b1;

      // Three pushes then three pops
      step(1'b1, 8'h11, 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b0, 1'b0);
      step(1'b1, 8'h33, 1'b0, 1'b0);
      chk("t1_count", count, 3);
      chk("t1_popflag", popflag, 3);
      chk("t1_ae", ae, 1);
      chk("t1_dout", dout, 8'h11);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t1_empty", empty, 1);
      chk("t1_dout0", dout, 0);

      // Fill to full, overflow, push+pop at full, drain through the wrap
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("t2_full", full, 1);
      chk("t2_count", count, DEPTH);
      chk("t2_pushflag", pushflag, 0);
      chk("t2_af", af, 1);
      step(1'b1, 8'hEE, 1'b0, 1'b0);
      chk("t2_ovf_count", count, DEPTH);
      step(1'b1, 8'hAA, 1'b1, 1'b0);
      chk("t2_pp_count", count, DEPTH);
      for (int i = 0; i < DEPTH; i++) begin
         if (i == DEPTH - 1) chk("t2_last", dout, 8'hAA);
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      chk("t2_empty", empty, 1);

      // Push+pop while empty, underflow after flush
      step(1'b1, 8'h5C, 1'b1, 1'b0);
      chk("t3_count", count, 1);
      chk("t3_dout", dout, 8'h5C);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      chk("t3_udf_count", count, 0);
`ifdef USB2M4_FIFO_ERR_CNT_EN
      chk("t3_udf_cnt", udf_cnt, 1);
`endif

      // Flush beats a simultaneous push
      for (int i = 0; i < 20; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      step(1'b1, 8'h77, 1'b0, 1'b1);
      chk("t4_count", count, 0);
      chk("t4_empty", empty, 1);
      chk("t4_popflag", popflag, 0);
      chk("t4_pushflag", pushflag, 4'hF);
      step(1'b1, 8'h33, 1'b0, 1'b0);
      chk("t4_dout", dout, 8'h33);

      // Randomized traffic with push-heavy and pop-heavy phases
      for (int i = 0; i < 1600; i++) begin
         int pw;
         pw = ((i / 400) % 2 == 0) ? 75 : 25;
         step(($urandom_range(99) < pw), 8'($urandom), ($urandom_range(99) >= pw),
              ($urandom_range(299) == 0));
      end
      step(1'b0, 8'h00, 1'b0, 1'b1);

      // Asynchronous reset between edges with count=100
      for (int i = 0; i < 100; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
      chk("t6_count100", count, 100);
      push = 1'b1; pop = 1'b1; din = 8'hC3;
      #2 reset = 1'b0;
      #1;
      chk("t6_count", count, 0);
      chk("t6_empty", empty, 1);
      chk("t6_ae", ae, 1);
      chk("t6_af", af, 0);
      chk("t6_full", full, 0);
      chk("t6_popflag", popflag, 0);
      chk("t6_pushflag", pushflag, 4'hF);
      chk("t6_dout", dout, 0);
      @(posedge clk);
      #2 push = 1'b0; pop = 1'b0;
      #1 reset = 1'b1;
      step(1'b1, 8'h01, 1'b0, 1'b0);
      chk("t6_dout01", dout, 8'h01);
      chk("t6_count1", count, 1);

      for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
      chk("sb_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
